// File: rtl/wupd_pkg.sv
// Shared types and constants for the weight-update scheduler.
// Macro WUPD_SATURATE_EN (see row_add_sat) selects saturating element sums.
package wupd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WAIT_D,
        WR,
        DONE
    } state_t;

    localparam int ROW_ELEMS = 16;
    localparam int NUM_ROWS  = 16;
    localparam int ELEM_W    = 18;

    localparam logic signed [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
    localparam logic signed [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/weight_update_sched_row_add_sat.sv
// NROW independent signed element adders, old + delta, reduced back to BITWIDTH.
// WUPD_SATURATE_EN defined: clamp to the signed range; undefined: two's-complement wrap.
module row_add_sat
    import wupd_pkg::*;
#(
    parameter int NROW     = ROW_ELEMS,
    parameter int BITWIDTH = ELEM_W
) (
    input  logic [NROW*BITWIDTH-1:0] old_row,
    input  logic [NROW*BITWIDTH-1:0] delta_row,
    output logic [NROW*BITWIDTH-1:0] sum_row
);

`ifdef WUPD_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [BITWIDTH-1:0] MAXV = (BITWIDTH == ELEM_W) ? BITWIDTH'(SAT_MAX)
                                         : {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic [BITWIDTH-1:0] MINV = (BITWIDTH == ELEM_W) ? BITWIDTH'(SAT_MIN)
                                         : {1'b1, {(BITWIDTH-1){1'b0}}};

    for (genvar j = 0; j < NROW; j++) begin : g_el
        logic [BITWIDTH-1:0] a;
        logic [BITWIDTH-1:0] d;
        logic [BITWIDTH:0]   s;
        logic                ovf_hi;
        logic                ovf_lo;

        assign a = old_row[j*BITWIDTH +: BITWIDTH];
        assign d = delta_row[j*BITWIDTH +: BITWIDTH];
        assign s = {a[BITWIDTH-1], a} + {d[BITWIDTH-1], d};
        // The top two sum bits disagree exactly when the result left the BITWIDTH range.
        assign ovf_hi = !s[BITWIDTH] && s[BITWIDTH-1];
        assign ovf_lo = s[BITWIDTH] && !s[BITWIDTH-1];

        assign sum_row[j*BITWIDTH +: BITWIDTH] = (SAT_EN && ovf_hi) ? MAXV
                                               : (SAT_EN && ovf_lo) ? MINV
                                               : s[BITWIDTH-1:0];
    end

endmodule

// File: rtl/weight_update_sched.sv
// Weight RAM controller: shares the read port between forward reads and a
// full-matrix read-modify-write update. Macro WUPD_SATURATE_EN: saturating sums.
module weight_update_sched
    import wupd_pkg::*;
#(
    parameter int NROW     = ROW_ELEMS,
    parameter int NCOL     = NUM_ROWS,
    parameter int BITWIDTH = ELEM_W,
    localparam int ADDR_BITWIDTH = clog2(NCOL),
    localparam int ROW_W = NROW * BITWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fwd_req,
    input  logic [ADDR_BITWIDTH-1:0] fwd_addr,
    output logic                     fwd_gnt,
    output logic                     fwd_rvalid,
    output logic [ROW_W-1:0]         fwd_row,
    input  logic                     upd_start,
    output logic                     upd_busy,
    output logic                     upd_done,
    input  logic                     delta_valid,
    output logic                     delta_ready,
    input  logic [ROW_W-1:0]         delta_row,
    output logic [ADDR_BITWIDTH-1:0] ram_addressIn,
    output logic [ADDR_BITWIDTH-1:0] ram_addressOut,
    output logic                     ram_writeEn,
    output logic [ROW_W-1:0]         ram_rowIn,
    input  logic [ROW_W-1:0]         ram_rowOut
);

    state_t                   state;
    logic [ADDR_BITWIDTH-1:0] k;
    logic [ROW_W-1:0]         old_row;
    logic [ROW_W-1:0]         sum_row;

    row_add_sat #(
        .NROW     (NROW),
        .BITWIDTH (BITWIDTH)
    ) u_add (
        .old_row   (old_row),
        .delta_row (delta_row),
        .sum_row   (sum_row)
    );

    // RD is the only state that claims the read address; everything else serves forward reads.
    assign fwd_gnt        = reset && fwd_req && (state != RD);
    assign ram_addressOut = (state == RD) ? k : (fwd_gnt ? fwd_addr : '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            k           <= '0;
            old_row     <= '0;
            fwd_rvalid  <= 1'b0;
            fwd_row     <= '0;
            upd_busy    <= 1'b0;
            upd_done    <= 1'b0;
            delta_ready <= 1'b0;
            ram_addressIn <= '0;
            ram_writeEn <= 1'b0;
            ram_rowIn   <= '0;
        end else begin
            upd_done   <= 1'b0;
            fwd_rvalid <= fwd_gnt;
            // The RAM answers at the negedge of the grant cycle, so the row is ready at this edge.
            if (fwd_gnt) fwd_row <= ram_rowOut;

            case (state)
                IDLE: begin
                    if (upd_start) begin
                        state    <= RD;
                        k        <= '0;
                        upd_busy <= 1'b1;
                    end
                end
                RD: begin
                    // Row k lands at the edge closing RD; capture it before CAP hands the port back.
                    old_row <= ram_rowOut;
                    state   <= CAP;
                end
                CAP: begin
                    delta_ready <= 1'b1;
                    state       <= WAIT_D;
                end
                WAIT_D: begin
                    if (delta_valid) begin
                        delta_ready   <= 1'b0;
                        ram_rowIn     <= sum_row;
                        ram_addressIn <= k;
                        ram_writeEn   <= 1'b1;
                        state         <= WR;
                    end
                end
                WR: begin
                    ram_writeEn   <= 1'b0;
                    ram_addressIn <= '0;
                    if (k == ADDR_BITWIDTH'(NCOL - 1)) begin
                        upd_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        k     <= k + ADDR_BITWIDTH'(1);
                        state <= RD;
                    end
                end
                DONE: begin
                    upd_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/weight_update_sched.md
Name: weight_update_sched

Overview:
- Controller for one weight RAM (NCOL rows of NROW x BITWIDTH-bit signed elements; negedge-clocked; separate write and read addresses; registered read port).
- Shares the RAM read port between the forward-pass datapath and a training update sequencer.
- The sequencer performs a full-matrix read-modify-write: W[k] <= W[k] + delta[k] for k = 0..NCOL-1, with deltas streamed from the gradient unit.
- Sits between the RAM and the forward/gradient units inside the network_train top level.

Parameters:
- NROW, 16, elements per RAM row.
- NCOL, 16, number of RAM rows (address range).
- BITWIDTH, 18, signed element width.
- ADDR_BITWIDTH, log2(NCOL), address width (derived).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- fwd_req  in  1  forward read request.
- fwd_addr  in  ADDR_BITWIDTH  forward read row address.
- fwd_gnt  out  1  forward request accepted this cycle.
- fwd_rvalid  out  1  fwd_row valid (one cycle after fwd_gnt).
- fwd_row  out  NROW*BITWIDTH  forward read data.
- upd_start  in  1  start full-matrix update (pulse).
- upd_busy  out  1  update in progress.
- upd_done  out  1  one-cycle completion pulse.
- delta_valid  in  1  delta row available.
- delta_ready  out  1  controller accepts a delta row.
- delta_row  in  NROW*BITWIDTH  per-element signed deltas, element j at bits [j*BITWIDTH +: BITWIDTH].
- ram_addressIn  out  ADDR_BITWIDTH  RAM write address.
- ram_addressOut  out  ADDR_BITWIDTH  RAM read address.
- ram_writeEn  out  1  RAM write enable.
- ram_rowIn  out  NROW*BITWIDTH  RAM write data.
- ram_rowOut  in  NROW*BITWIDTH  RAM read data.

Behaviour:
- RAM timing: outputs change on posedge; the RAM samples on the following negedge. Read data is valid at the next posedge (1-cycle read latency). A write lands in the same cycle.
- Reset (reset==0 at posedge): state IDLE, column counter k=0. All outputs are 0: fwd_gnt, fwd_rvalid, fwd_row, upd_busy, upd_done, delta_ready, ram_*. Reset mid-update abandons the update; rows already written stay written. The controller does not drive the RAM's own reset pin.
- FSM states: IDLE, RD, CAP, WAIT_D, WR, DONE.
  - IDLE: upd_start -> RD with k=0.
  - RD: ram_addressOut=k.
  - CAP: latch ram_rowOut into old_row.
  - WAIT_D: delta_ready=1. On delta_valid, register old_row+delta_row into ram_rowIn and go to WR.
  - WR: ram_writeEn=1, ram_addressIn=k. If k==NCOL-1, go to DONE; else k++ and go to RD.
  - DONE: upd_done=1 -> IDLE.
- upd_busy=1 in every state except IDLE. upd_start is ignored while busy.
- Minimum 4 cycles per row. Start sampled at cycle t gives upd_done at cycle t+1+4*NCOL (t+65 at defaults).
- Arbitration: fwd_gnt = fwd_req && state!=RD. Only RD owns the read address; forward reads proceed in every other state. The update is never stalled by forward traffic.
- On grant, ram_addressOut=fwd_addr. The next cycle has fwd_rvalid=1 and fwd_row=ram_rowOut. fwd_row holds its value until the next grant.
- Same-row read during WR returns the pre-update value.
- ram_writeEn is never asserted outside WR.
- Arithmetic: per element, a signed BITWIDTH+1 sum is reduced to BITWIDTH (see optional feature). Elements are independent.
- Delta stall: WAIT_D holds indefinitely. Exactly one delta row is consumed per column, NCOL per update.

Optional Feature:
- Macro: WUPD_SATURATE_EN.
- Defined: each element sum clamps to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- Undefined: two's-complement wrap (truncate to BITWIDTH bits).

Decomposition:
- Package wupd_pkg: state enum (IDLE..DONE), log2 function, element-width constants, SAT_MAX/SAT_MIN constants.
- Sub-module row_add_sat: NROW parallel element adders with saturate/wrap selected by the macro; purely combinational.

Test Plan:
- Preload all elements=400, deltas all +5 always valid, upd_start -> 16 writes at addresses 0..15, every element =405, upd_done exactly 65 cycles after start.
- With WUPD_SATURATE_EN: element 131000 + delta 2000 -> 131071; -131000 + (-2000) -> -131072. Without the macro: 131000 + 2000 wraps to -129144.
- fwd_req held high during an update -> fwd_gnt low only in RD cycles; fwd_row for addr 3 read after its WR cycle = updated value, read in that WR cycle = old value.
- delta_valid withheld 10 cycles on column 7 -> FSM holds WAIT_D, no write to row 7 until the handshake, total latency +10.
- reset driven low while k=9 -> next cycle all outputs 0 and upd_busy=0. Rows 0..8 updated, 9..15 unchanged. A new upd_start restarts from row 0.
- upd_start pulsed while busy -> ignored, exactly one upd_done.
